// File: rtl/coef_pkg.sv
// Shared biquad coefficient definitions: tap ordering, mode codes and the
// Q8.14 coefficient table reused by every filter block in the family.
package coef_pkg;

    localparam int COEF_TBL_W    = 22;
    localparam int COEF_TBL_FRAC = 14;

    localparam logic [2:0] IDX_B0 = 3'd0;
    localparam logic [2:0] IDX_B1 = 3'd1;
    localparam logic [2:0] IDX_B2 = 3'd2;
    localparam logic [2:0] IDX_A1 = 3'd3;
    localparam logic [2:0] IDX_A2 = 3'd4;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_LOW  = 2'd1,
        MODE_MED  = 2'd2,
        MODE_HIGH = 2'd3
    } mode_e;

    // Entries are 22-bit two's complement with 14 fractional bits; MODE_OFF is all zero.
    function automatic logic [COEF_TBL_W-1:0] coef_lookup(input logic [1:0] mode,
                                                          input logic [2:0] idx);
        logic [COEF_TBL_W-1:0] c;
        c = 22'h000000;
        case (mode)
            MODE_LOW: begin
                case (idx)
                    IDX_B0:  c = 22'h000040;
                    IDX_B1:  c = 22'h000080;
                    IDX_B2:  c = 22'h000040;
                    IDX_A1:  c = 22'h007D71;
                    IDX_A2:  c = 22'h3FC277;
                    default: c = 22'h000000;
                endcase
            end
            MODE_MED: begin
                case (idx)
                    IDX_B0:  c = 22'h000800;
                    IDX_B1:  c = 22'h001000;
                    IDX_B2:  c = 22'h000800;
                    IDX_A1:  c = 22'h00423D;
                    IDX_A2:  c = 22'h3FF000;
                    default: c = 22'h000000;
                endcase
            end
            MODE_HIGH: begin
                case (idx)
                    IDX_B0:  c = 22'h002000;
                    IDX_B1:  c = 22'h3FC000;
                    IDX_B2:  c = 22'h002000;
                    IDX_A1:  c = 22'h3F9A2D;
                    IDX_A2:  c = 22'h3FE000;
                    default: c = 22'h000000;
                endcase
            end
            default: c = 22'h000000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/coef_rom.sv
// Combinational coefficient lookup: selects a table entry and rescales it
// from the table's Q.14 format to the caller's WIDTH/FRAC format.
module coef_rom
    import coef_pkg::*;
#(
    parameter int WIDTH  = 22,
    parameter int FRAC   = 14,
    parameter int NTAPS  = 5,
    parameter int NMODES = 4
) (
    input  logic [$clog2(NMODES)-1:0] mode,
    input  logic [$clog2(NTAPS)-1:0]  idx,
    output logic [WIDTH-1:0]          coef
);

    localparam int SH_L = (FRAC > COEF_TBL_FRAC) ? (FRAC - COEF_TBL_FRAC) : 0;
    localparam int SH_R = (FRAC < COEF_TBL_FRAC) ? (COEF_TBL_FRAC - FRAC) : 0;

    logic signed [COEF_TBL_W-1:0] tbl_s;

    // Table lookup with sign-preserving fixed-point realignment.
    always_comb begin
        tbl_s = coef_lookup(2'(mode), 3'(idx));
        coef  = WIDTH'((64'(tbl_s) <<< SH_L) >>> SH_R);
    end

endmodule

// File: rtl/coef_bank_seq.sv
// Streams the NTAPS coefficients of the selected filter mode to a downstream
// MAC over a valid/ready handshake, one stream per sample_start pulse.
module coef_bank_seq
    import coef_pkg::*;
#(
    parameter int WIDTH  = 22,
    parameter int FRAC   = 14,
    parameter int NTAPS  = 5,
    parameter int NMODES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [$clog2(NMODES)-1:0] sel,
    input  logic                      sample_start,
    input  logic                      coef_ready,
    output logic                      coef_valid,
    output logic [WIDTH-1:0]          coef_data,
    output logic [$clog2(NTAPS)-1:0]  coef_idx,
    output logic                      coef_last,
    output logic                      busy,
    output logic [$clog2(NMODES)-1:0] mode_active,
    output logic                      overrun
);

    localparam int IDX_W = $clog2(NTAPS);
    localparam int MODE_W = $clog2(NMODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               ovr_q, ovr_d;
    logic               load_s;
    logic               xfer_s;
    logic [WIDTH-1:0]   rom_coef_s;

    assign xfer_s = valid_q & coef_ready;

    // Next-state logic; a final transfer coinciding with sample_start restarts seamlessly.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        load_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_start) begin
                    state_d = ST_STREAM;
                    mode_d  = sel;
                    idx_d   = ZERO_IDX;
                    load_s  = 1'b1;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = (LAST_IDX == ZERO_IDX);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (xfer_s && (idx_q == LAST_IDX)) begin
                    if (sample_start) begin
                        mode_d = sel;
                        idx_d  = ZERO_IDX;
                        load_s = 1'b1;
                        last_d = (LAST_IDX == ZERO_IDX);
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                    end
                end else if (xfer_s) begin
                    idx_d  = idx_q + IDX_W'(1);
                    load_s = 1'b1;
                    last_d = (idx_d == LAST_IDX);
                    if (sample_start) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end else begin
                    if (sample_start) begin
                        ovr_d = 1'b1;
                    end else begin
                        ovr_d = ovr_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    coef_rom #(
        .WIDTH  (WIDTH),
        .FRAC   (FRAC),
        .NTAPS  (NTAPS),
        .NMODES (NMODES)
    ) u_rom (
        .mode (mode_d),
        .idx  (idx_d),
        .coef (rom_coef_s)
    );

    // Data register loads only on a tap advance, so a stalled word holds.
    always_comb begin
        if (load_s) begin
            data_d = rom_coef_s;
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= ZERO_IDX;
            mode_q  <= {MODE_W{1'b0}};
            data_q  <= {WIDTH{1'b0}};
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign coef_valid  = valid_q;
    assign coef_data   = data_q;
    assign coef_idx    = idx_q;
    assign coef_last   = last_q;
    assign busy        = busy_q;
    assign mode_active = mode_q;
    assign overrun     = ovr_q;

endmodule

// File: doc/coef_bank_seq.md
COEF_BANK_SEQ -- requirements
Module: coef_bank_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 22, giving the coefficient word width in two's complement.
REQ-002 The block SHALL have parameter FRAC, default 14, giving the number of fractional bits (1.0 = 2^FRAC).
REQ-003 The block SHALL have parameter NTAPS, default 5, giving the coefficients per filter in order b0,b1,b2,a1,a2 (idx 0..4).
REQ-004 The block SHALL have parameter NMODES, default 4, giving the modes: 0 = off, 1 = low, 2 = medium, 3 = high.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port sel, input, $clog2(NMODES) bits: requested mode.
REQ-008 The block SHALL have port sample_start, input, 1 bit: one-cycle pulse marking a new input sample.
REQ-009 The block SHALL have port coef_ready, input, 1 bit: downstream MAC accepts coef_data.
REQ-010 The block SHALL have port coef_valid, output, 1 bit: coef_data/coef_idx are valid.
REQ-011 The block SHALL have port coef_data, output, WIDTH bits: current coefficient.
REQ-012 The block SHALL have port coef_idx, output, $clog2(NTAPS) bits: tap index of coef_data.
REQ-013 The block SHALL have port coef_last, output, 1 bit: coef_idx == NTAPS-1 while coef_valid.
REQ-014 The block SHALL have port busy, output, 1 bit: a stream is in progress.
REQ-015 The block SHALL have port mode_active, output, $clog2(NMODES) bits: mode used by the current or last stream.
REQ-016 The block SHALL have port overrun, output, 1 bit: sticky flag, a sample_start arrived while busy and not at the final transfer.

Function
REQ-017 The FSM SHALL have exactly two states, IDLE and STREAM; all outputs SHALL be registered.
REQ-018 In IDLE, sample_start=1 SHALL, on that edge, latch sel into mode_active, set coef_idx=0, load the tap-0 coefficient, set coef_valid=1, busy=1 and move to STREAM (latency 1 cycle).
REQ-019 A transfer SHALL occur on any edge with coef_valid=1 and coef_ready=1; on a transfer with coef_idx<NTAPS-1, coef_idx SHALL increment and coef_data SHALL load the next tap.
REQ-020 With coef_valid=1 and coef_ready=0, coef_data, coef_idx and coef_last SHALL hold stable.
REQ-021 On the transfer of tap NTAPS-1 with sample_start=0, the block SHALL return to IDLE with coef_valid=0 and busy=0.
REQ-022 On the transfer of tap NTAPS-1 with sample_start=1 in the same cycle, the block SHALL restart at tap 0 with the new sel latched, with no idle cycle and no overrun.
REQ-023 sample_start in STREAM other than at the final transfer SHALL be ignored and SHALL set overrun; overrun SHALL clear only on reset.
REQ-024 Changes on sel SHALL affect only the next accepted sample_start; mode_active SHALL never change mid-stream.
REQ-025 Mode 0 SHALL stream NTAPS zero words with normal handshake timing.
REQ-026 Coefficient table entries SHALL be WIDTH-bit signed Q(WIDTH-FRAC).FRAC; a1 (idx 3) SHALL be 0x007D71 (1.960), 0x00423D (1.035) and 0x3F9A2D (-1.591) for modes 1, 2 and 3.
REQ-027 With coef_ready held high, the NTAPS words SHALL appear on consecutive cycles N+1..N+NTAPS after sample_start at cycle N.

Reset
REQ-028 While reset_n=0, the block SHALL be in IDLE with coef_valid=0, coef_data=0, coef_idx=0, coef_last=0, busy=0, mode_active=0 and overrun=0, asynchronously.
REQ-029 Reset asserted mid-stream SHALL abandon the stream; after release the block SHALL emit nothing until the next sample_start.

Structure
REQ-030 A shared package coef_pkg SHALL hold the tap-order constants (IDX_B0..IDX_A2), the mode codes and the coefficient table, so that other filter blocks can reuse them.
REQ-031 A single combinational sub-module coef_rom(mode, idx -> coef) SHALL implement the lookup; coef_bank_seq SHALL own the FSM, counter and output registers.

Verification
REQ-032 The bench SHALL apply reset, then sel=1 with a sample_start pulse and coef_ready=1, and SHALL check that coef_valid is high for exactly 5 cycles, idx 0..4, idx 3 = 0x007D71, and coef_last only at idx 4.
REQ-033 The bench SHALL apply sel=3 with coef_ready low for 3 cycles at idx 2, and SHALL check that data and idx hold, the stream completes, and idx 3 = 0x3F9A2D.
REQ-034 The bench SHALL change sel from 2 to 1 mid-stream, and SHALL check that the current stream uses 0x00423D at idx 3 and the next uses 0x007D71.
REQ-035 The bench SHALL pulse sample_start at idx 1, and SHALL check that overrun=1 stays set, the stream is unaffected, and no restart occurs.
REQ-036 The bench SHALL pulse sample_start coincident with the idx-4 transfer, and SHALL check that idx 0 follows on the next cycle with busy staying high.
REQ-037 The bench SHALL assert reset_n=0 at idx 2, and SHALL check that all outputs are 0 immediately and that there is no output after release until sample_start.
